// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) helpers and types for the AES InvMixColumns datapath.
package aes_gf_pkg;

  localparam logic [7:0]  AES_RED_CONST = 8'h1B;
  localparam int unsigned NUM_BYTES     = 4;

  // Row index of each byte within a column; row 0 lives in bits [31:24].
  localparam logic [1:0] COL_B0 = 2'd0;
  localparam logic [1:0] COL_B1 = 2'd1;
  localparam logic [1:0] COL_B2 = 2'd2;
  localparam logic [1:0] COL_B3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBL  = 2'd1,
    OUT  = 2'd2
  } imc_state_e;

  // Multiply a byte by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_RED_CONST : 8'h00);
  endfunction

  // Extract the byte of a column that belongs to row idx.
  function automatic logic [7:0] col_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [3:0][7:0] v;
    v = w;
    return v[2'd3 - idx];
  endfunction

endpackage

// File: rtl/aes_xtime_x4.sv
// Four-lane combinational xtime over a 32-bit column.
module aes_xtime_x4
  import aes_gf_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  logic [3:0][7:0] lanes_in;
  logic [3:0][7:0] lanes_out;

  assign lanes_in = word_i;
  assign word_o   = lanes_out;

  // Independent doubling of every byte lane.
  always_comb begin
    lanes_out = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      lanes_out[i[1:0]] = xtime(lanes_in[i[1:0]]);
    end
  end

endmodule

// File: rtl/aes_inv_mixcol_seq.sv
// Sequential AES InvMixColumns: one column in, three doubling cycles, one
// column out. Define AES_INVMIX_FWD_EN to add a mode port selecting forward
// MixColumns (mode=1) with identical timing.
module aes_inv_mixcol_seq
  import aes_gf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col
`ifdef AES_INVMIX_FWD_EN
  ,
  input  logic        mode
`endif
);

  imc_state_e  state_q;
  logic [1:0]  cnt_q;
  logic [31:0] a_q, x2_q, x4_q, x8_q;
  logic [31:0] out_col_q;
  logic        out_valid_q;
  logic        in_ready_q;
`ifdef AES_INVMIX_FWD_EN
  logic        mode_q;
`endif

  logic [31:0] dbl_in;
  logic [31:0] dbl_out;
  logic [31:0] result_d;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;

  // Inverse mix: row r uses coefficient index (c - r) mod 4 over {0E,0B,0D,09}.
  function automatic logic [31:0] inv_mix(input logic [31:0] a, input logic [31:0] x2,
                                          input logic [31:0] x4, input logic [31:0] x8);
    logic [3:0][7:0] m09, m0b, m0d, m0e, res;
    logic [7:0]      acc;
    logic [1:0]      k;
    res = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      m09[i[1:0]] = col_byte(x8, i[1:0]) ^ col_byte(a, i[1:0]);
      m0b[i[1:0]] = col_byte(x8, i[1:0]) ^ col_byte(x2, i[1:0]) ^ col_byte(a, i[1:0]);
      m0d[i[1:0]] = col_byte(x8, i[1:0]) ^ col_byte(x4, i[1:0]) ^ col_byte(a, i[1:0]);
      m0e[i[1:0]] = col_byte(x8, i[1:0]) ^ col_byte(x4, i[1:0]) ^ col_byte(x2, i[1:0]);
    end
    for (int unsigned r = 0; r < NUM_BYTES; r++) begin
      acc = '0;
      for (int unsigned c = 0; c < NUM_BYTES; c++) begin
        k = c[1:0] - r[1:0];
        case (k)
          COL_B0:  acc = acc ^ m0e[c[1:0]];
          COL_B1:  acc = acc ^ m0b[c[1:0]];
          COL_B2:  acc = acc ^ m0d[c[1:0]];
          default: acc = acc ^ m09[c[1:0]];
        endcase
      end
      res[2'd3 - r[1:0]] = acc;
    end
    return res;
  endfunction

`ifdef AES_INVMIX_FWD_EN
  // Forward mix: row r uses coefficient index (c - r) mod 4 over {02,03,01,01}.
  function automatic logic [31:0] fwd_mix(input logic [31:0] a, input logic [31:0] x2);
    logic [3:0][7:0] res;
    logic [7:0]      acc;
    logic [1:0]      k;
    res = '0;
    for (int unsigned r = 0; r < NUM_BYTES; r++) begin
      acc = '0;
      for (int unsigned c = 0; c < NUM_BYTES; c++) begin
        k = c[1:0] - r[1:0];
        case (k)
          COL_B0:  acc = acc ^ col_byte(x2, c[1:0]);
          COL_B1:  acc = acc ^ col_byte(x2, c[1:0]) ^ col_byte(a, c[1:0]);
          default: acc = acc ^ col_byte(a, c[1:0]);
        endcase
      end
      res[2'd3 - r[1:0]] = acc;
    end
    return res;
  endfunction
`endif

  // Select the operand of the shared doubler for the current DBL step.
  // Counter value 3 never occurs; it routes X8 so the register stays observable.
  always_comb begin
    dbl_in = '0;
    case (cnt_q)
      2'd0:    dbl_in = a_q;
      2'd1:    dbl_in = x2_q;
      2'd2:    dbl_in = x4_q;
      default: dbl_in = x8_q;
    endcase
  end

  aes_xtime_x4 u_xtime (
    .word_i (dbl_in),
    .word_o (dbl_out)
  );

  // Final combine, using the X8 value being registered on the last step.
  always_comb begin
    result_d = inv_mix(a_q, x2_q, x4_q, dbl_out);
`ifdef AES_INVMIX_FWD_EN
    if (mode_q) begin
      result_d = fwd_mix(a_q, x2_q);
    end
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      x2_q        <= '0;
      x4_q        <= '0;
      x8_q        <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef AES_INVMIX_FWD_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_col;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= DBL;
`ifdef AES_INVMIX_FWD_EN
            mode_q     <= mode;
`endif
          end
        end
        DBL: begin
          case (cnt_q)
            2'd0: begin
              x2_q  <= dbl_out;
              cnt_q <= 2'd1;
            end
            2'd1: begin
              x4_q  <= dbl_out;
              cnt_q <= 2'd2;
            end
            default: begin
              x8_q        <= dbl_out;
              out_col_q   <= result_d;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= OUT;
            end
          endcase
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_mixcol_seq.sv
// Scoreboard bench for aes_inv_mixcol_seq; reference uses generic GF(2^8)
// multiplication and the (Inv)MixColumns coefficient matrix.
module tb_aes_inv_mixcol_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_col;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_col;
  logic        mode;

  always #5 clk = ~clk;

  aes_inv_mixcol_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col)
`ifdef AES_INVMIX_FWD_EN
    ,
    .mode      (mode)
`endif
  );

  typedef struct {
    logic [31:0] col;
    int unsigned cyc;
  } exp_t;

  exp_t        expq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_acc_cyc = 0;

  logic        acc_now = 1'b0;
  logic        rst_now = 1'b0;
  logic [31:0] acc_col = '0;
  logic        acc_mode = 1'b0;

  logic        prev_ov = 1'b0;
  logic        prev_or = 1'b0;
  logic [31:0] prev_col = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int unsigned p, aa;
    p  = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 32'h100) != 0) aa = aa ^ 32'h11B;
    end
    return p[7:0];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] col, input logic fwd);
    logic [7:0] a[4];
    logic [7:0] coef[4];
    logic [7:0] b;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) a[i] = col[31 - 8*i -: 8];
    if (fwd) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      b = '0;
      for (int c = 0; c < 4; c++) b = b ^ gmul(a[c], coef[(c - r + 4) % 4]);
      res[31 - 8*r -: 8] = b;
    end
    return res;
  endfunction

  // Sample inputs/outputs away from the active edge; check output protocol.
  always @(negedge clk) begin
    acc_now  = rst_n && in_valid && in_ready;
    acc_col  = in_col;
    acc_mode = mode;
    rst_now  = !rst_n;
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (expq.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else chk("latency", cyc - expq[0].cyc, 32'd3);
      end
      if (prev_ov && !prev_or) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_col", out_col, prev_col);
      end
      if (prev_ov && prev_or) chk("valid_drops", 32'(out_valid), 32'd0);
      if (out_valid) chk("in_ready_low_in_out", 32'(in_ready), 32'd0);
      if (out_valid && out_ready && expq.size() != 0) begin
        chk("out_col", out_col, expq[0].col);
        void'(expq.pop_front());
      end
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_col = out_col;
    end
  end

  // Record accepted columns with their reference results.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst_now) begin
      expq.delete();
    end else if (acc_now) begin
      e.col = model(acc_col, acc_mode);
      e.cyc = cyc;
      expq.push_back(e);
      last_acc_cyc = cyc;
    end
  end

  task automatic send(input logic [31:0] col, input logic m, input bit keep);
    bit got;
    in_col   = col;
    mode     = m;
    in_valid = 1'b1;
    got      = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      if (acc_now) got = 1;
    end
    #1;
    if (!keep) in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      #1;
      if (expq.size() == 0 && !out_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned acc_prev;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_col = '0; out_ready = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_col", out_col, 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vectors.
    out_ready = 1'b1;
    send(32'h8E4DA1BC, 1'b0, 0); wait_idle();
    send(32'h9FDC589D, 1'b0, 0); wait_idle();
    send(32'h01010101, 1'b0, 0); wait_idle();
    send(32'hC6C6C6C6, 1'b0, 0); wait_idle();

    // Backpressure with ignored input pulses.
    out_ready = 1'b0;
    send(32'h12345678, 1'b0, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    if (!seen) chk("bp_out_valid_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_col   = $urandom;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    send(32'hA5A55A5A, 1'b0, 0); wait_idle();

    // Reset while in DBL step 1.
    send(32'hDEADBEEF, 1'b0, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_col", out_col, 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;

    // Back-to-back accepts.
    out_ready = 1'b1;
    acc_prev  = 0;
    for (int k = 0; k < 6; k++) begin
      send($urandom, 1'b0, 1);
      if (k > 0) chk("b2b_spacing", last_acc_cyc - acc_prev, 32'd5);
      acc_prev = last_acc_cyc;
      in_col = $urandom;
    end
    in_valid = 1'b0;
    wait_idle();

`ifdef AES_INVMIX_FWD_EN
    send(32'hDB135345, 1'b1, 0); wait_idle();
    send(32'h8E4DA1BC, 1'b0, 0); wait_idle();
    send(32'hF20A225C, 1'b1, 0); wait_idle();
`endif

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid  = $urandom_range(0, 1);
      in_col    = $urandom;
`ifdef AES_INVMIX_FWD_EN
      mode      = $urandom_range(0, 1);
`endif
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("queue_empty", expq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
